// File: rtl/baby_mem_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : baby_mem_bridge
//  Description : Byte-serial bridge between the Manchester Baby 32-bit word
//                memory port and the 8-bit TinyTapeout IO bus. Each access
//                sends a header byte {we, pad, addr}, then moves one word as
//                four bytes LSB first, with a per-byte idle timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module baby_mem_bridge #(
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic [31:0]       mem_rdata_o,
  output logic              mem_ack_o,
  output logic              mem_err_o,
  output logic [7:0]        bus_data_o,
  output logic              bus_oe_o,
  output logic              bus_strobe_o,
  input  logic              bus_ready_i,
  input  logic [7:0]        bus_data_i,
  input  logic              bus_valid_i
);

  // Timeout counter only needs to count up to TIMEOUT itself.
  localparam int c_to_w = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HEADER = 3'd1,
    S_WDATA  = 3'd2,
    S_RDATA  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [23:0]         r_shadow;   // bytes 0..2 of a load; byte 3 goes straight to r_rdata
  logic [31:0]         r_rdata;
  logic [1:0]          r_cnt;
  logic [c_to_w-1:0]   r_to;
  logic                r_err;
  logic [7:0]          w_hdr;
  logic                w_xfer;
  logic                w_busy;
  logic                w_to_hit;
  logic                w_timeout;

  assign mem_rdata_o = r_rdata;

  // Header byte: write flag in bit 7, address right-aligned and zero padded.
  assign w_hdr    = {r_we, 7'(r_addr)};
  assign w_busy   = (r_state == S_HEADER) || (r_state == S_WDATA) || (r_state == S_RDATA);
  // Abort on the idle cycle that would bring the counter up to TIMEOUT.
  assign w_to_hit = (TIMEOUT != 0) && ((int'(r_to) + 1) == TIMEOUT);

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode, byte-transfer detection and bus/ack outputs.
  always_comb begin
    w_next       = r_state;
    w_xfer       = 1'b0;
    w_timeout    = 1'b0;
    bus_oe_o     = 1'b0;
    bus_strobe_o = 1'b0;
    bus_data_o   = 8'h00;
    mem_ack_o    = 1'b0;
    mem_err_o    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mem_req_i) w_next = S_HEADER;
      end
      S_HEADER: begin
        bus_oe_o     = 1'b1;
        bus_strobe_o = 1'b1;
        bus_data_o   = w_hdr;
        w_xfer       = bus_ready_i;
        if (w_xfer) w_next = r_we ? S_WDATA : S_RDATA;
      end
      S_WDATA: begin
        bus_oe_o     = 1'b1;
        bus_strobe_o = 1'b1;
        bus_data_o   = r_wdata[{r_cnt, 3'b000} +: 8];
        w_xfer       = bus_ready_i;
        if (w_xfer && (r_cnt == 2'd3)) w_next = S_DONE;
      end
      S_RDATA: begin
        w_xfer = bus_valid_i;
        if (w_xfer && (r_cnt == 2'd3)) w_next = S_DONE;
      end
      S_DONE: begin
        mem_ack_o = 1'b1;
        mem_err_o = r_err;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_busy && !w_xfer && w_to_hit) begin
      w_timeout = 1'b1;
      w_next    = S_DONE;
    end
  end

  // Request latching, byte counter, timeout counter and load-data capture.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= 32'h0;
      r_shadow <= 24'h0;
      r_rdata  <= 32'h0;
      r_cnt    <= 2'd0;
      r_to     <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (mem_req_i) begin
            r_we    <= mem_we_i;
            r_addr  <= mem_addr_i;
            r_wdata <= mem_wdata_i;
            r_cnt   <= 2'd0;
            r_to    <= '0;
          end
        end
        S_HEADER: begin
          if (w_xfer) r_cnt <= 2'd0;
        end
        S_WDATA: begin
          if (w_xfer) r_cnt <= r_cnt + 2'd1;
        end
        S_RDATA: begin
          if (w_xfer) begin
            case (r_cnt)
              2'd0:    r_shadow[7:0]   <= bus_data_i;
              2'd1:    r_shadow[15:8]  <= bus_data_i;
              2'd2:    r_shadow[23:16] <= bus_data_i;
              default: r_rdata         <= {bus_data_i, r_shadow};
            endcase
            r_cnt <= r_cnt + 2'd1;
          end
        end
        S_DONE: begin
          r_err <= 1'b0;
          r_to  <= '0;
        end
        default: ;
      endcase
      if (w_busy) begin
        r_err <= w_timeout;
        if (w_xfer) r_to <= '0;
        else        r_to <= r_to + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_baby_mem_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_baby_mem_bridge
//  Description : Self-checking bench for baby_mem_bridge. A host model offers
//                or withholds bus handshakes; expected bytes, ack timing and
//                load data follow from the bridge's protocol rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_baby_mem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req, mem_we;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        bus_ready, bus_valid;
  logic [7:0]  bus_din;

  logic [31:0] a_rdata, b_rdata;
  logic        a_ack, b_ack, a_err, b_err, a_oe, b_oe, a_stb, b_stb;
  logic [7:0]  a_dout, b_dout;

  // Monitor selects the default instance (0) or the TIMEOUT=4 instance (1).
  logic        sel = 1'b0;
  logic [31:0] m_rdata;
  logic        m_ack, m_err, m_oe, m_stb;
  logic [7:0]  m_dout;
  assign m_rdata = sel ? b_rdata : a_rdata;
  assign m_ack   = sel ? b_ack   : a_ack;
  assign m_err   = sel ? b_err   : a_err;
  assign m_oe    = sel ? b_oe    : a_oe;
  assign m_stb   = sel ? b_stb   : a_stb;
  assign m_dout  = sel ? b_dout  : a_dout;

  always #5 clk = ~clk;

  baby_mem_bridge u_dut (
    .clk_i(clk), .reset_i(rst), .mem_req_i(mem_req), .mem_we_i(mem_we),
    .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata), .mem_rdata_o(a_rdata),
    .mem_ack_o(a_ack), .mem_err_o(a_err), .bus_data_o(a_dout), .bus_oe_o(a_oe),
    .bus_strobe_o(a_stb), .bus_ready_i(bus_ready), .bus_data_i(bus_din),
    .bus_valid_i(bus_valid)
  );

  baby_mem_bridge #(.ADDR_W(5), .TIMEOUT(4)) u_dut_to (
    .clk_i(clk), .reset_i(rst), .mem_req_i(mem_req), .mem_we_i(mem_we),
    .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata), .mem_rdata_o(b_rdata),
    .mem_ack_o(b_ack), .mem_err_o(b_err), .bus_data_o(b_dout), .bus_oe_o(b_oe),
    .bus_strobe_o(b_stb), .bus_ready_i(bus_ready), .bus_data_i(bus_din),
    .bus_valid_i(bus_valid)
  );

  int n_vec = 0;
  int n_err = 0;

  // Observations of the last transaction driven by do_txn.
  logic [9:0]  obs_q[$];    // {oe, strobe, data} at each accepted outgoing byte
  logic [7:0]  hold_q[$];   // bus_data_o during forced stall cycles
  int          obs_ack_k, obs_nx, obs_last, obs_oe_bad;
  logic        obs_err;
  logic [31:0] obs_rdata;
  logic [31:0] model_rdata;

  // Host model: requests one transaction, then offers one byte handshake per
  // cycle unless a stall is scheduled; records everything until the ack.
  task automatic do_txn(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rword, input int stall_at, input int stall_len,
                        input bit rnd, input bit valid_en, input bit hold_req);
    int  left;
    bit  offer;
    obs_q.delete(); hold_q.delete();
    obs_ack_k = -1; obs_nx = 0; obs_last = 0; obs_oe_bad = 0; obs_err = 1'b0; obs_rdata = 'x;
    left = stall_len;
    @(negedge clk);
    mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wdata;
    bus_ready = 1'b0; bus_valid = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (!hold_req) begin
        mem_req = 1'b0; mem_we = 1'($urandom); mem_addr = 5'($urandom); mem_wdata = $urandom;
      end
      if (m_ack) begin
        obs_ack_k = k; obs_err = m_err; obs_rdata = m_rdata;
        break;
      end
      if (obs_nx >= 1 && !we && (m_oe || m_stb)) obs_oe_bad++;
      bus_ready = 1'b0; bus_valid = 1'b0; bus_din = 8'($urandom);
      offer = 1'b0;
      if (obs_nx < 5) begin
        if (obs_nx == stall_at && left > 0) begin
          left--;
          if (we || obs_nx == 0) hold_q.push_back(m_dout);
        end else if (!(rnd && $urandom_range(0, 2) == 0)) begin
          offer = (obs_nx == 0) || we || valid_en;
        end
      end
      if (offer) begin
        if (obs_nx == 0 || we) begin
          bus_ready = 1'b1;
          obs_q.push_back({m_oe, m_stb, m_dout});
        end else begin
          bus_valid = 1'b1;
          bus_din   = rword[8*(obs_nx-1) +: 8];
        end
        obs_nx++;
        obs_last = k;
      end else begin
        // Handshakes that must be ignored in the current phase.
        if (we || obs_nx == 0) bus_valid = 1'($urandom);
        else                   bus_ready = 1'($urandom);
      end
    end
    bus_ready = 1'b0; bus_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0; mem_addr = 5'h0; mem_wdata = 32'h0;
    bus_ready = 1'b0; bus_valid = 1'b0; bus_din = 8'h0;
    repeat (3) @(negedge clk);
    n_vec++; if (a_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata got %h exp %h", a_rdata, 32'h0); end
    n_vec++; if ({a_ack, a_err, a_oe, a_stb} !== 4'b0) begin n_err++; $display("FAIL reset_ctl got %b exp %b", {a_ack, a_err, a_oe, a_stb}, 4'b0); end
    n_vec++; if (a_dout !== 8'h0) begin n_err++; $display("FAIL reset_dout got %h exp %h", a_dout, 8'h0); end
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if ({a_ack, a_oe, a_stb} !== 3'b0) begin n_err++; $display("FAIL idle_ctl got %b exp %b", {a_ack, a_oe, a_stb}, 3'b0); end
    model_rdata = 32'h0;
  endtask

  task automatic test_store();
    logic [7:0] exp_b[5];
    exp_b = '{8'h93, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    do_txn(1'b1, 5'h13, 32'hDEADBEEF, 32'h0, -1, 0, 1'b0, 1'b1, 1'b0);
    n_vec++; if (obs_q.size() != 5) begin n_err++; $display("FAIL store_nbytes got %0d exp 5", obs_q.size()); end
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (i >= obs_q.size() || obs_q[i] !== {2'b11, exp_b[i]}) begin
        n_err++; $display("FAIL store_byte%0d got %h exp %h", i, (i < obs_q.size()) ? obs_q[i] : 10'h0, {2'b11, exp_b[i]});
      end
    end
    n_vec++; if (obs_ack_k != 6) begin n_err++; $display("FAIL store_ack_cycle got %0d exp 6", obs_ack_k); end
    n_vec++; if (obs_err !== 1'b0) begin n_err++; $display("FAIL store_err got %b exp 0", obs_err); end
    @(negedge clk);
    n_vec++; if ({m_ack, m_stb} !== 2'b00) begin n_err++; $display("FAIL store_ack_pulse got %b exp 00", {m_ack, m_stb}); end
  endtask

  task automatic test_load();
    do_txn(1'b0, 5'h02, 32'h0, 32'h12345678, -1, 0, 1'b0, 1'b1, 1'b0);
    n_vec++; if (obs_q.size() != 1 || obs_q[0] !== 10'h302) begin n_err++; $display("FAIL load_header got %h exp %h", (obs_q.size() > 0) ? obs_q[0] : 10'h0, 10'h302); end
    n_vec++; if (obs_oe_bad != 0) begin n_err++; $display("FAIL load_oe got %0d exp 0", obs_oe_bad); end
    n_vec++; if (obs_ack_k != 6) begin n_err++; $display("FAIL load_ack_cycle got %0d exp 6", obs_ack_k); end
    n_vec++; if (obs_rdata !== 32'h12345678) begin n_err++; $display("FAIL load_rdata got %h exp %h", obs_rdata, 32'h12345678); end
    n_vec++; if (obs_err !== 1'b0) begin n_err++; $display("FAIL load_err got %b exp 0", obs_err); end
    model_rdata = 32'h12345678;
    @(negedge clk);
    n_vec++; if (m_rdata !== model_rdata) begin n_err++; $display("FAIL load_rdata_hold got %h exp %h", m_rdata, model_rdata); end
  endtask

  task automatic test_stall();
    do_txn(1'b1, 5'h13, 32'hDEADBEEF, 32'h0, 3, 3, 1'b0, 1'b1, 1'b0);
    n_vec++; if (hold_q.size() != 3) begin n_err++; $display("FAIL stall_cycles got %0d exp 3", hold_q.size()); end
    for (int i = 0; i < hold_q.size(); i++) begin
      n_vec++; if (hold_q[i] !== 8'hAD) begin n_err++; $display("FAIL stall_hold%0d got %h exp %h", i, hold_q[i], 8'hAD); end
    end
    n_vec++; if (obs_q.size() != 5 || obs_q[3] !== 10'h3AD) begin n_err++; $display("FAIL stall_byte got %h exp %h", (obs_q.size() > 3) ? obs_q[3] : 10'h0, 10'h3AD); end
    n_vec++; if (obs_ack_k != 9) begin n_err++; $display("FAIL stall_ack_cycle got %0d exp 9", obs_ack_k); end
    n_vec++; if (obs_err !== 1'b0) begin n_err++; $display("FAIL stall_err got %b exp 0", obs_err); end
  endtask

  task automatic test_random();
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wd, rw;
    logic [9:0]  exp_q[$];
    for (int t = 0; t < 10; t++) begin
      we = 1'($urandom); addr = 5'($urandom); wd = $urandom; rw = $urandom;
      do_txn(we, addr, wd, rw, -1, 0, 1'b1, 1'b1, 1'b0);
      exp_q.delete();
      exp_q.push_back({2'b11, we, 2'b00, addr});
      if (we) for (int b = 0; b < 4; b++) exp_q.push_back({2'b11, wd[8*b +: 8]});
      else    model_rdata = rw;
      n_vec++; if (obs_q != exp_q) begin n_err++; $display("FAIL rnd%0d_bytes got %p exp %p", t, obs_q, exp_q); end
      n_vec++; if (obs_nx != 5 || obs_ack_k != obs_last + 1) begin n_err++; $display("FAIL rnd%0d_ack got cycle %0d after %0d bytes exp cycle %0d after 5", t, obs_ack_k, obs_nx, obs_last + 1); end
      n_vec++; if (obs_rdata !== model_rdata || obs_err !== 1'b0) begin n_err++; $display("FAIL rnd%0d_rdata got %h/%b exp %h/0", t, obs_rdata, obs_err, model_rdata); end
      n_vec++; if (obs_oe_bad != 0) begin n_err++; $display("FAIL rnd%0d_oe got %0d exp 0", t, obs_oe_bad); end
    end
  endtask

  task automatic test_back_to_back();
    int hdr_j, ack_j;
    do_txn(1'b1, 5'h0A, 32'hCAFEF00D, 32'h0, -1, 0, 1'b0, 1'b1, 1'b1);
    n_vec++; if (obs_ack_k != 6) begin n_err++; $display("FAIL b2b_first_ack got %0d exp 6", obs_ack_k); end
    hdr_j = -1;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      bus_ready = 1'b1;
      if (m_stb) begin
        hdr_j = j;
        n_vec++; if (m_dout !== 8'h8A) begin n_err++; $display("FAIL b2b_header got %h exp %h", m_dout, 8'h8A); end
        mem_req = 1'b0;
        break;
      end
    end
    n_vec++; if (hdr_j != 2) begin n_err++; $display("FAIL b2b_gap got %0d exp 2", hdr_j); end
    ack_j = -1;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      if (m_ack) begin ack_j = j; break; end
    end
    bus_ready = 1'b0;
    n_vec++; if (ack_j != 5) begin n_err++; $display("FAIL b2b_second_ack got %0d exp 5", ack_j); end
  endtask

  task automatic test_reset_mid();
    int acks;
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 5'h13; mem_wdata = 32'hDEADBEEF; bus_ready = 1'b1;
    @(negedge clk); mem_req = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if (m_dout !== 8'hBE) begin n_err++; $display("FAIL mid_byte1 got %h exp %h", m_dout, 8'hBE); end
    rst = 1'b1;
    #1;
    n_vec++; if ({m_ack, m_err, m_oe, m_stb, m_dout, m_rdata} !== 44'h0) begin
      n_err++; $display("FAIL mid_async_clear got %h exp 0", {m_ack, m_err, m_oe, m_stb, m_dout, m_rdata});
    end
    acks = 0;
    for (int j = 0; j < 4; j++) begin @(negedge clk); if (m_ack) acks++; end
    rst = 1'b0; bus_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin @(negedge clk); if (m_ack) acks++; end
    n_vec++; if (acks != 0) begin n_err++; $display("FAIL mid_no_ack got %0d exp 0", acks); end
    model_rdata = 32'h0;
    do_txn(1'b1, 5'h07, 32'h01020304, 32'h0, -1, 0, 1'b0, 1'b1, 1'b0);
    n_vec++; if (obs_q.size() != 5 || obs_q[0] !== 10'h387 || obs_q[4] !== 10'h301) begin
      n_err++; $display("FAIL mid_fresh_bytes got %p exp hdr 387 last 301", obs_q);
    end
    n_vec++; if (obs_ack_k != 6 || obs_err !== 1'b0) begin n_err++; $display("FAIL mid_fresh_ack got %0d/%b exp 6/0", obs_ack_k, obs_err); end
  endtask

  task automatic test_timeout();
    logic [31:0] r;
    rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
    sel = 1'b1;
    r = $urandom;
    do_txn(1'b0, 5'h11, 32'h0, r, -1, 0, 1'b0, 1'b1, 1'b0);
    n_vec++; if (obs_rdata !== r || obs_err !== 1'b0) begin n_err++; $display("FAIL to_preload got %h/%b exp %h/0", obs_rdata, obs_err, r); end
    do_txn(1'b0, 5'h04, 32'h0, 32'hFFFF_FFFF, -1, 0, 1'b0, 1'b0, 1'b0);
    n_vec++; if (obs_ack_k != 6 || obs_nx != 1) begin n_err++; $display("FAIL to_ack_cycle got %0d after %0d bytes exp 6 after 1", obs_ack_k, obs_nx); end
    n_vec++; if (obs_err !== 1'b1) begin n_err++; $display("FAIL to_err got %b exp 1", obs_err); end
    n_vec++; if (obs_rdata !== r) begin n_err++; $display("FAIL to_rdata got %h exp %h", obs_rdata, r); end
    @(negedge clk);
    n_vec++; if ({m_ack, m_err} !== 2'b00 || m_rdata !== r) begin n_err++; $display("FAIL to_after got %b/%h exp 00/%h", {m_ack, m_err}, m_rdata, r); end
    sel = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store();
    test_load();
    test_stall();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
